id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset:
  clk  in  1  rising-edge clock for all state
  rst  in  1  asynchronous active-low reset; all state cleared while low
REQ-002 The block SHALL have these control inputs:
  freeze  in  1  hold all registered state (upstream hazard stall)
  flush  in  1  taken branch in EX; discard the instruction being captured
  bubble  in  1  load-use hazard; insert NOP into EX
REQ-003 The block SHALL have these ID-side inputs:
  validIn  in  1  ID holds a real instruction
  ctrlIn  in  9  {exeCmd[3:0], memRead, memWrite, writeBackEn, b, sOut} from the control unit
  pcIn  in  32  PC+4 of the instruction
  val1In  in  32  Rn register value
  valRmIn  in  32  Rm/Rd register value
  immIn  in  1  immediate-operand bit (I)
  shiftOperandIn  in  12  shifter operand field
  signedImm24In  in  24  branch offset
  destIn  in  4  destination register number
  carryIn  in  1  status-register C flag
REQ-004 The block SHALL have these outputs, each registered with the same width and meaning as its input:
  validOut, ctrlOut, pcOut, val1Out, valRmOut, immOut, shiftOperandOut, signedImm24Out, destOut, carryOut
REQ-005 The block SHALL output stallCount (8 bits): a saturating count of frozen or bubbled cycles.

Function
REQ-006 On each rising clk edge with rst high, the block SHALL apply exactly one action, in priority order: flush, bubble, freeze, load.
REQ-007 Flush SHALL clear validOut, ctrlOut and every data output to 0, regardless of freeze or bubble.
REQ-008 Bubble (without flush) SHALL clear validOut and ctrlOut to 0 and SHALL leave the data outputs at their held values.
REQ-009 Freeze (without flush or bubble) SHALL hold every output, validOut included.
REQ-010 Load SHALL capture every input into its corresponding output.
REQ-011 Load with validIn=0 SHALL force ctrlOut to 0, so an invalid instruction never writes back, accesses memory or branches.
REQ-012 Whenever validOut=0, ctrlOut SHALL equal 0.
REQ-013 Latency SHALL be exactly one cycle from input to output on load.
REQ-014 The block SHALL have no combinational path from any input to any output.
REQ-015 stallCount SHALL increment by 1 on each edge where (freeze or bubble) and not flush.
REQ-016 stallCount SHALL saturate at 255 and stay there, with no wrap-around to 0.
REQ-017 Flush SHALL NOT change stallCount.

Reset
REQ-018 While rst is low, all outputs SHALL be 0 immediately (asynchronous, independent of clk), stallCount included.
REQ-019 After rst deasserts, the first rising edge SHALL perform a normal prioritized action; no post-reset bubble is inserted.
REQ-020 Reset asserted mid-freeze or mid-bubble SHALL discard the held instruction; its contents SHALL NOT reappear after release.

Verification
REQ-021 Load path: validIn=1, ctrlIn=9'b0010_0_0_1_0_1 (ADD,S), pcIn=0x10, destIn=3 -> next edge: ctrlOut=0x45, pcOut=0x10, destOut=3, validOut=1.
REQ-022 Freeze hold: load instruction A, then freeze=1 for 3 cycles with new inputs B -> outputs stay A, stallCount=3; release -> B captured on next edge.
REQ-023 Bubble vs. flush priority: bubble=1 -> ctrlOut=0, validOut=0, val1Out unchanged, stallCount+1; flush=1 with freeze=1 and bubble=1 -> all outputs 0, stallCount unchanged.
REQ-024 Invalid capture: validIn=0, ctrlIn=9'h1FF -> ctrlOut=0, validOut=0.
REQ-025 Saturation: freeze held 300 cycles -> stallCount reaches 255 and stays 255.
REQ-026 Async reset: rst low between clock edges during freeze -> all outputs 0 before the next edge; after release and one load edge, outputs equal the new inputs.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush/bubble/freeze control and a saturating stall counter.
// Priority per edge: flush, then bubble, then freeze, then load.
module id_ex_stage_reg (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        freeze_i,
  input  logic        flush_i,
  input  logic        bubble_i,
  input  logic        valid_i,
  input  logic [8:0]  ctrl_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] val1_i,
  input  logic [31:0] val_rm_i,
  input  logic        imm_i,
  input  logic [11:0] shift_operand_i,
  input  logic [23:0] signed_imm24_i,
  input  logic [3:0]  dest_i,
  input  logic        carry_i,
  output logic        valid_o,
  output logic [8:0]  ctrl_o,
  output logic [31:0] pc_o,
  output logic [31:0] val1_o,
  output logic [31:0] val_rm_o,
  output logic        imm_o,
  output logic [11:0] shift_operand_o,
  output logic [23:0] signed_imm24_o,
  output logic [3:0]  dest_o,
  output logic        carry_o,
  output logic [7:0]  stall_count_o
);

  logic        valid_q, valid_d;
  logic [8:0]  ctrl_q, ctrl_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] val1_q, val1_d;
  logic [31:0] val_rm_q, val_rm_d;
  logic        imm_q, imm_d;
  logic [11:0] shift_operand_q, shift_operand_d;
  logic [23:0] signed_imm24_q, signed_imm24_d;
  logic [3:0]  dest_q, dest_d;
  logic        carry_q, carry_d;
  logic [7:0]  stall_count_q, stall_count_d;

  always_comb begin
    valid_d         = valid_q;
    ctrl_d          = ctrl_q;
    pc_d            = pc_q;
    val1_d          = val1_q;
    val_rm_d        = val_rm_q;
    imm_d           = imm_q;
    shift_operand_d = shift_operand_q;
    signed_imm24_d  = signed_imm24_q;
    dest_d          = dest_q;
    carry_d         = carry_q;

    if (flush_i) begin
      valid_d         = 1'b0;
      ctrl_d          = '0;
      pc_d            = '0;
      val1_d          = '0;
      val_rm_d        = '0;
      imm_d           = 1'b0;
      shift_operand_d = '0;
      signed_imm24_d  = '0;
      dest_d          = '0;
      carry_d         = 1'b0;
    end else if (bubble_i) begin
      // NOP into EX: kill control only, data operands stay as they were
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!freeze_i) begin
      valid_d         = valid_i;
      // An invalid slot must never carry side-effecting control bits
      ctrl_d          = valid_i ? ctrl_i : '0;
      pc_d            = pc_i;
      val1_d          = val1_i;
      val_rm_d        = val_rm_i;
      imm_d           = imm_i;
      shift_operand_d = shift_operand_i;
      signed_imm24_d  = signed_imm24_i;
      dest_d          = dest_i;
      carry_d         = carry_i;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!flush_i && (freeze_i || bubble_i) && (stall_count_q != 8'hFF)) begin
      stall_count_d = stall_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q         <= 1'b0;
      ctrl_q          <= '0;
      pc_q            <= '0;
      val1_q          <= '0;
      val_rm_q        <= '0;
      imm_q           <= 1'b0;
      shift_operand_q <= '0;
      signed_imm24_q  <= '0;
      dest_q          <= '0;
      carry_q         <= 1'b0;
      stall_count_q   <= '0;
    end else begin
      valid_q         <= valid_d;
      ctrl_q          <= ctrl_d;
      pc_q            <= pc_d;
      val1_q          <= val1_d;
      val_rm_q        <= val_rm_d;
      imm_q           <= imm_d;
      shift_operand_q <= shift_operand_d;
      signed_imm24_q  <= signed_imm24_d;
      dest_q          <= dest_d;
      carry_q         <= carry_d;
      stall_count_q   <= stall_count_d;
    end
  end

  assign valid_o         = valid_q;
  assign ctrl_o          = ctrl_q;
  assign pc_o            = pc_q;
  assign val1_o          = val1_q;
  assign val_rm_o        = val_rm_q;
  assign imm_o           = imm_q;
  assign shift_operand_o = shift_operand_q;
  assign signed_imm24_o  = signed_imm24_q;
  assign dest_o          = dest_q;
  assign carry_o         = carry_q;
  assign stall_count_o   = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed testbench for id_ex_stage_reg: load, freeze, bubble/flush priority,
// invalid capture, stall-counter saturation and asynchronous reset.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, bubble;
  logic        valid_in;
  logic [8:0]  ctrl_in;
  logic [31:0] pc_in, val1_in, val_rm_in;
  logic        imm_in;
  logic [11:0] shop_in;
  logic [23:0] simm_in;
  logic [3:0]  dest_in;
  logic        carry_in;

  logic        valid_out;
  logic [8:0]  ctrl_out;
  logic [31:0] pc_out, val1_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shop_out;
  logic [23:0] simm_out;
  logic [3:0]  dest_out;
  logic        carry_out;
  logic [7:0]  stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .freeze_i        (freeze),
    .flush_i         (flush),
    .bubble_i        (bubble),
    .valid_i         (valid_in),
    .ctrl_i          (ctrl_in),
    .pc_i            (pc_in),
    .val1_i          (val1_in),
    .val_rm_i        (val_rm_in),
    .imm_i           (imm_in),
    .shift_operand_i (shop_in),
    .signed_imm24_i  (simm_in),
    .dest_i          (dest_in),
    .carry_i         (carry_in),
    .valid_o         (valid_out),
    .ctrl_o          (ctrl_out),
    .pc_o            (pc_out),
    .val1_o          (val1_out),
    .val_rm_o        (val_rm_out),
    .imm_o           (imm_out),
    .shift_operand_o (shop_out),
    .signed_imm24_o  (simm_out),
    .dest_o          (dest_out),
    .carry_o         (carry_out),
    .stall_count_o   (stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] c, input logic [31:0] pc,
                       input logic [31:0] v1, input logic [31:0] vrm, input logic im,
                       input logic [11:0] sh, input logic [23:0] si, input logic [3:0] d,
                       input logic cy);
    valid_in  = v;
    ctrl_in   = c;
    pc_in     = pc;
    val1_in   = v1;
    val_rm_in = vrm;
    imm_in    = im;
    shop_in   = sh;
    simm_in   = si;
    dest_in   = d;
    carry_in  = cy;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, ".ctrl"},  {23'd0, ctrl_out}, 32'd0);
    check({tag, ".pc"},    pc_out, 32'd0);
    check({tag, ".val1"},  val1_out, 32'd0);
    check({tag, ".valrm"}, val_rm_out, 32'd0);
    check({tag, ".imm"},   {31'd0, imm_out}, 32'd0);
    check({tag, ".shop"},  {20'd0, shop_out}, 32'd0);
    check({tag, ".simm"},  {8'd0, simm_out}, 32'd0);
    check({tag, ".dest"},  {28'd0, dest_out}, 32'd0);
    check({tag, ".carry"}, {31'd0, carry_out}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    freeze = 1'b0;
    flush  = 1'b0;
    bubble = 1'b0;
    drive(1'b1, 9'h1FF, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 12'hFFF,
          24'hFF_FFFF, 4'hF, 1'b1);
    #3;
    check_zero("reset");
    check("reset.stall", {24'd0, stall_count}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Load A: ADD with S set -> ctrl 0x045
    drive(1'b1, 9'b0010_0_0_1_0_1, 32'h10, 32'h1111, 32'h2222, 1'b1, 12'hABC, 24'h123456,
          4'd3, 1'b1);
    step();
    check("loadA.ctrl",  {23'd0, ctrl_out}, 32'h45);
    check("loadA.pc",    pc_out, 32'h10);
    check("loadA.dest",  {28'd0, dest_out}, 32'd3);
    check("loadA.valid", {31'd0, valid_out}, 32'd1);
    check("loadA.val1",  val1_out, 32'h1111);
    check("loadA.valrm", val_rm_out, 32'h2222);
    check("loadA.shop",  {20'd0, shop_out}, 32'hABC);
    check("loadA.simm",  {8'd0, simm_out}, 32'h123456);
    check("loadA.carry", {31'd0, carry_out}, 32'd1);
    check("loadA.stall", {24'd0, stall_count}, 32'd0);

    // Freeze three cycles while B waits on the inputs
    freeze = 1'b1;
    drive(1'b1, 9'h1A3, 32'h20, 32'h3333, 32'h4444, 1'b0, 12'h123, 24'h654321, 4'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("freeze.pc",    pc_out, 32'h10);
      check("freeze.ctrl",  {23'd0, ctrl_out}, 32'h45);
      check("freeze.valid", {31'd0, valid_out}, 32'd1);
    end
    check("freeze.stall", {24'd0, stall_count}, 32'd3);
    freeze = 1'b0;
    step();
    check("loadB.pc",    pc_out, 32'h20);
    check("loadB.ctrl",  {23'd0, ctrl_out}, 32'h1A3);
    check("loadB.dest",  {28'd0, dest_out}, 32'd7);
    check("loadB.val1",  val1_out, 32'h3333);
    check("loadB.stall", {24'd0, stall_count}, 32'd3);

    // Bubble: control killed, data held
    bubble = 1'b1;
    drive(1'b1, 9'h0F0, 32'h30, 32'h5555, 32'h6666, 1'b1, 12'h555, 24'h111111, 4'd9, 1'b1);
    step();
    check("bubble.ctrl",  {23'd0, ctrl_out}, 32'd0);
    check("bubble.valid", {31'd0, valid_out}, 32'd0);
    check("bubble.val1",  val1_out, 32'h3333);
    check("bubble.pc",    pc_out, 32'h20);
    check("bubble.stall", {24'd0, stall_count}, 32'd4);
    bubble = 1'b0;

    // Load D, then flush with freeze and bubble also raised
    drive(1'b1, 9'h0FF, 32'h40, 32'h7777, 32'h8888, 1'b1, 12'h777, 24'h222222, 4'd5, 1'b1);
    step();
    check("loadD.pc",   pc_out, 32'h40);
    check("loadD.ctrl", {23'd0, ctrl_out}, 32'h0FF);
    flush  = 1'b1;
    freeze = 1'b1;
    bubble = 1'b1;
    step();
    check_zero("flush");
    check("flush.stall", {24'd0, stall_count}, 32'd4);
    flush  = 1'b0;
    freeze = 1'b0;
    bubble = 1'b0;

    // Invalid instruction capture
    drive(1'b0, 9'h1FF, 32'h50, 32'h9999, 32'hAAAA, 1'b0, 12'h321, 24'h333333, 4'd2, 1'b0);
    step();
    check("invalid.ctrl",  {23'd0, ctrl_out}, 32'd0);
    check("invalid.valid", {31'd0, valid_out}, 32'd0);
    check("invalid.pc",    pc_out, 32'h50);

    // Saturation: 251 frozen cycles take the count from 4 to 255
    freeze = 1'b1;
    repeat (251) step();
    check("sat.reach", {24'd0, stall_count}, 32'd255);
    repeat (49) step();
    check("sat.hold", {24'd0, stall_count}, 32'd255);
    check("sat.pc",   pc_out, 32'h50);

    // Async reset mid-freeze, between clock edges
    drive(1'b1, 9'h045, 32'h60, 32'hBBBB, 32'hCCCC, 1'b1, 12'h999, 24'h444444, 4'd4, 1'b1);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    check("async.stall", {24'd0, stall_count}, 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // Still frozen: held state must be the reset state, not the old instruction
    check("postrst.pc",    pc_out, 32'd0);
    check("postrst.valid", {31'd0, valid_out}, 32'd0);
    check("postrst.stall", {24'd0, stall_count}, 32'd1);
    freeze = 1'b0;
    drive(1'b1, 9'h123, 32'h70, 32'hDDDD, 32'hEEEE, 1'b0, 12'h0F0, 24'h0A0B0C, 4'd11, 1'b0);
    step();
    check("loadE.valid", {31'd0, valid_out}, 32'd1);
    check("loadE.ctrl",  {23'd0, ctrl_out}, 32'h123);
    check("loadE.pc",    pc_out, 32'h70);
    check("loadE.val1",  val1_out, 32'hDDDD);
    check("loadE.valrm", val_rm_out, 32'hEEEE);
    check("loadE.shop",  {20'd0, shop_out}, 32'h0F0);
    check("loadE.simm",  {8'd0, simm_out}, 32'h0A0B0C);
    check("loadE.dest",  {28'd0, dest_out}, 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
